// File: rtl/v_red_pkg.sv
// Shared types and constants for the vector reduction issue block:
// FSM states, SEW and opSel encodings, and the per-byte identity helper.
package v_red_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALAR = 2'd1,
    STREAM = 2'd2
  } red_state_e;

  localparam logic [1:0] SEW_8   = 2'b00;
  localparam logic [1:0] SEW_16  = 2'b01;
  localparam logic [1:0] SEW_32  = 2'b10;
  localparam logic [1:0] SEW_BAD = 2'b11;

  // Logical ops decode opSel[1:0], arithmetic ops decode opSel[2:1].
  localparam logic [1:0] LOP_AND  = 2'b01;
  localparam logic [1:0] LOP_OR   = 2'b10;
  localparam logic [1:0] LOP_XOR  = 2'b11;
  localparam logic [1:0] SUM_SUM  = 2'b00;
  localparam logic [1:0] SUM_MIN  = 2'b01;
  localparam logic [1:0] SUM_MAX  = 2'b10;
  localparam logic [1:0] SUM_MINU = 2'b11;

  localparam logic [7:0] ID_ZERO     = 8'h00;
  localparam logic [7:0] ID_ONES     = 8'hFF;
  localparam logic [7:0] ID_SMAX_TOP = 8'h7F;
  localparam logic [7:0] ID_SMIN_TOP = 8'h80;

  // Identity byte for one lane; top_byte marks the most significant byte of its element.
  function automatic logic [7:0] ident_byte(input logic [2:0] op_sel,
                                            input logic       lop_sum,
                                            input logic       top_byte);
    logic [7:0] id_s;
    id_s = ID_ZERO;
    if (lop_sum) begin
      if (op_sel[1:0] == LOP_AND) id_s = ID_ONES;
      else                        id_s = ID_ZERO;
    end else begin
      case (op_sel[2:1])
        SUM_MIN:  id_s = top_byte ? ID_SMAX_TOP : ID_ONES;
        SUM_MAX:  id_s = top_byte ? ID_SMIN_TOP : ID_ZERO;
        SUM_MINU: id_s = ID_ONES;
        default:  id_s = ID_ZERO;
      endcase
    end
    return id_s;
  endfunction

endpackage

// File: rtl/v_red_pad.sv
// Combinational beat padding: bytes of elements that are past vl or masked off
// are replaced by the identity byte of the reduction operation.
module v_red_pad
  import v_red_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int VL_WIDTH   = 8
) (
  input  logic [DATA_WIDTH-1:0]   beat,
  input  logic [1:0]              sew,
  input  logic [2:0]              op_sel,
  input  logic                    lop_sum,
  input  logic [VL_WIDTH-1:0]     active,
  input  logic [DATA_WIDTH/8-1:0] mask,
  output logic [DATA_WIDTH-1:0]   padded
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [LANES-1:0] LANE0 = {{(LANES-1){1'b0}}, 1'b1};

  int   bpe_s;
  int   elem_s;
  int   first_s;
  int   act_s;
  logic top_s;
  logic keep_s;

  // An element is kept when it is below the active count and its lowest byte lane is enabled.
  always_comb begin
    padded  = beat;
    bpe_s   = 32'sd1 << sew;
    act_s   = int'(active);
    elem_s  = 32'sd0;
    first_s = 32'sd0;
    top_s   = 1'b0;
    keep_s  = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      elem_s  = b >> sew;
      first_s = elem_s << sew;
      top_s   = ((b % bpe_s) == (bpe_s - 32'sd1));
      keep_s  = (elem_s < act_s) && (|(mask & (LANE0 << first_s)));
      if (keep_s) padded[8*b +: 8] = beat[8*b +: 8];
      else        padded[8*b +: 8] = ident_byte(op_sel, lop_sum, top_s);
    end
  end

endmodule

// File: rtl/v_red_issue.sv
// Reduction issue: reads the scalar seed then the vs2 beats and emits padded, framed beats.
// Define V_RED_ISSUE_MASK_EN to add cmd_vm / rd_mask for masked reductions.
module v_red_issue
  import v_red_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int VL_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_opSel,
  input  logic                  cmd_lop_sum,
  input  logic [1:0]            cmd_sew,
  input  logic [VL_WIDTH-1:0]   cmd_vl,
  input  logic [ADDR_WIDTH-1:0] cmd_vs1_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_vs2_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_vd_addr,
`ifdef V_RED_ISSUE_MASK_EN
  input  logic                  cmd_vm,
  input  logic [3:0]            rd_mask,
`endif
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_vec0,
  output logic [DATA_WIDTH-1:0] out_vec1,
  output logic                  out_valid,
  output logic                  out_start,
  output logic                  out_end,
  output logic                  out_lop_sum,
  output logic [2:0]            out_opSel,
  output logic [1:0]            out_sew,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  localparam int LANES = DATA_WIDTH / 8;

  red_state_e            state_r, next_s;
  logic [2:0]            op_r, p_op_r;
  logic                  lop_r, p_lop_r;
  logic [1:0]            sew_r, p_sew_r;
  logic                  vm_r, p_vm_r, vm_s;
  logic [VL_WIDTH-1:0]   rem_r, epb_s, active_s, p_active_r;
  logic [ADDR_WIDTH-1:0] vs1_r, vs2_r, vd_r, ptr_r, p_vd_r;
  logic                  go_s, last_s;
  logic                  p_valid_r, p_start_r, p_end_r, p_seed_r;
  logic [DATA_WIDTH-1:0] seed_r, pad_s;
  logic [LANES-1:0]      mask_in_s, mask_s;

`ifdef V_RED_ISSUE_MASK_EN
  assign vm_s      = cmd_vm;
  assign mask_in_s = rd_mask;
`else
  assign vm_s      = 1'b1;
  assign mask_in_s = {LANES{1'b1}};
`endif

  // A dropped command (vl=0 or reserved SEW) still handshakes but never leaves IDLE.
  assign go_s = (state_r == IDLE) && cmd_valid && (cmd_vl != {VL_WIDTH{1'b0}}) && (cmd_sew != SEW_BAD);

  // Elements per beat and how many of them remain live in the current beat.
  always_comb begin
    epb_s = VL_WIDTH'(LANES) >> sew_r;
    if (rem_r <= epb_s) begin
      last_s   = 1'b1;
      active_s = rem_r;
    end else begin
      last_s   = 1'b0;
      active_s = epb_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= next_s;
  end

  // FSM next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (go_s) next_s = SCALAR;
        else      next_s = IDLE;
      end
      SCALAR: next_s = STREAM;
      STREAM: begin
        if (last_s) next_s = IDLE;
        else        next_s = STREAM;
      end
      default: next_s = IDLE;
    endcase
  end

  // FSM outputs: handshake and read port.
  always_comb begin
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = {ADDR_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (rst) cmd_ready = 1'b1;
        else     cmd_ready = 1'b0;
      end
      SCALAR: begin
        rd_en   = 1'b1;
        rd_addr = vs1_r;
      end
      STREAM: begin
        rd_en   = 1'b1;
        rd_addr = ptr_r;
      end
      default: begin
        rd_en   = 1'b0;
        rd_addr = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Command latch plus the vs2 pointer and remaining-element counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r  <= 3'd0;
      lop_r <= 1'b0;
      sew_r <= 2'd0;
      vm_r  <= 1'b1;
      rem_r <= {VL_WIDTH{1'b0}};
      vs1_r <= {ADDR_WIDTH{1'b0}};
      vs2_r <= {ADDR_WIDTH{1'b0}};
      vd_r  <= {ADDR_WIDTH{1'b0}};
      ptr_r <= {ADDR_WIDTH{1'b0}};
    end else if (go_s) begin
      op_r  <= cmd_opSel;
      lop_r <= cmd_lop_sum;
      sew_r <= cmd_sew;
      vm_r  <= vm_s;
      rem_r <= cmd_vl;
      vs1_r <= cmd_vs1_addr;
      vs2_r <= cmd_vs2_addr;
      vd_r  <= cmd_vd_addr;
      ptr_r <= cmd_vs2_addr;
    end else if (state_r == STREAM) begin
      ptr_r <= ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      rem_r <= last_s ? {VL_WIDTH{1'b0}} : (rem_r - epb_s);
    end
  end

  // Beat metadata travels with the read so a following command can reload the latch early.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_valid_r  <= 1'b0;
      p_start_r  <= 1'b0;
      p_end_r    <= 1'b0;
      p_seed_r   <= 1'b0;
      p_active_r <= {VL_WIDTH{1'b0}};
      p_op_r     <= 3'd0;
      p_lop_r    <= 1'b0;
      p_sew_r    <= 2'd0;
      p_vm_r     <= 1'b1;
      p_vd_r     <= {ADDR_WIDTH{1'b0}};
    end else begin
      p_valid_r  <= (state_r == STREAM);
      p_start_r  <= (state_r == STREAM) && (ptr_r == vs2_r);
      p_end_r    <= (state_r == STREAM) && last_s;
      p_seed_r   <= (state_r == SCALAR);
      p_active_r <= active_s;
      p_op_r     <= op_r;
      p_lop_r    <= lop_r;
      p_sew_r    <= sew_r;
      p_vm_r     <= vm_r;
      p_vd_r     <= vd_r;
    end
  end

  // Seed word returned by the SCALAR read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          seed_r <= {DATA_WIDTH{1'b0}};
    else if (p_seed_r) seed_r <= rd_data;
  end

  assign mask_s = p_vm_r ? {LANES{1'b1}} : mask_in_s;

  v_red_pad #(
    .DATA_WIDTH (DATA_WIDTH),
    .VL_WIDTH   (VL_WIDTH)
  ) u_pad (
    .beat    (rd_data),
    .sew     (p_sew_r),
    .op_sel  (p_op_r),
    .lop_sum (p_lop_r),
    .active  (p_active_r),
    .mask    (mask_s),
    .padded  (pad_s)
  );

  // Registered output beat; every field is zero whenever no beat is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_start   <= 1'b0;
      out_end     <= 1'b0;
      out_lop_sum <= 1'b0;
      out_opSel   <= 3'd0;
      out_sew     <= 2'd0;
      out_addr    <= {ADDR_WIDTH{1'b0}};
      out_vec0    <= {DATA_WIDTH{1'b0}};
      out_vec1    <= {DATA_WIDTH{1'b0}};
    end else if (p_valid_r) begin
      out_valid   <= 1'b1;
      out_start   <= p_start_r;
      out_end     <= p_end_r;
      out_lop_sum <= p_lop_r;
      out_opSel   <= p_op_r;
      out_sew     <= p_sew_r;
      out_addr    <= p_vd_r;
      out_vec0    <= pad_s;
      out_vec1    <= p_start_r ? seed_r : {DATA_WIDTH{1'b0}};
    end else begin
      out_valid   <= 1'b0;
      out_start   <= 1'b0;
      out_end     <= 1'b0;
      out_lop_sum <= 1'b0;
      out_opSel   <= 3'd0;
      out_sew     <= 2'd0;
      out_addr    <= {ADDR_WIDTH{1'b0}};
      out_vec0    <= {DATA_WIDTH{1'b0}};
      out_vec1    <= {DATA_WIDTH{1'b0}};
    end
  end

endmodule
